host_rd_line_fetcher: RTL and testbench

Descriptor-driven Avalon-MM read master that fetches a contiguous run of 64-byte cache lines from host memory for the ternary matmul datapath. It sits directly upstream of the CCIP host-read adapter: it drives that adapter's address/read/burstcount and consumes its readdata. Returned lines are buffered in a credit-protected FIFO and presented to the compute engine as a valid/ready stream with an end-of-run marker.

---
 rtl/host_rd_line_fetcher.sv | 197 +++++++++++++++++++
 tb/tb_host_rd_line_fetcher.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_rd_line_fetcher.sv
// Descriptor-driven Avalon-MM read master: fetches a run of 64-byte lines
// in CCIP-aligned bursts of 1/2/4, buffers returns in a credit-protected FIFO
// and streams them out with an end-of-run marker.
// Optional statistics counters are enabled by defining HOST_RD_FETCH_STATS_EN.
module host_rd_line_fetcher #(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned ADDR_WIDTH  = 48,
    parameter int unsigned BURST_WIDTH = 3,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [LEN_WIDTH-1:0]   cmd_lines,
    output logic [ADDR_WIDTH-1:0]  avm_address,
    output logic                   avm_read,
    output logic [BURST_WIDTH-1:0] avm_burstcount,
    input  logic                   avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]  avm_readdata,
    input  logic                   avm_readdatavalid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   done,
    output logic                   err
`ifdef HOST_RD_FETCH_STATS_EN
    ,
    output logic [31:0]            stat_lines,
    output logic [31:0]            stat_stall
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [LEN_WIDTH-1:0]  total_q;
    logic [LEN_WIDTH-1:0]  delivered_q;
    logic [CNT_W-1:0]      pending_q;
    logic [CNT_W-1:0]      fifo_count_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [2:0]            burst_c;
    logic                  credit_ok;
    logic                  issue_fire;
    logic                  cmd_fire;
    logic                  beat_ok;
    logic                  stray;
    logic                  out_hs;
    logic                  last_hs;

    // Largest CCIP-legal burst for the current address that fits the remaining count
    always_comb begin
        burst_c = 3'd1;
        if (addr_q[7:6] == 2'b00 && remaining_q >= LEN_WIDTH'(4)) begin
            burst_c = 3'd4;
        end else if (!addr_q[6] && remaining_q >= LEN_WIDTH'(2)) begin
            burst_c = 3'd2;
        end
    end

    // Pending (in flight + buffered) never exceeds the FIFO depth, so returns need no backpressure
    assign credit_ok  = (CNT_W'(FIFO_DEPTH) - pending_q) >= CNT_W'(burst_c);
    assign issue_fire = (state == ISSUE) && credit_ok && !avm_waitrequest;
    assign cmd_fire   = (state == IDLE) && cmd_valid;
    assign beat_ok    = avm_readdatavalid && (pending_q != fifo_count_q);
    assign stray      = avm_readdatavalid && (pending_q == fifo_count_q);
    assign out_valid  = (fifo_count_q != '0);
    assign out_hs     = out_valid && out_ready;
    assign out_last   = out_valid && (delivered_q == total_q - LEN_WIDTH'(1));
    assign last_hs    = out_hs && out_last;
    assign out_data   = fifo_mem[rd_ptr_q];

    assign avm_address    = addr_q;
    assign avm_burstcount = BURST_WIDTH'(burst_c);
    assign err            = err_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        avm_read  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (cmd_lines == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                avm_read = credit_ok;
                if (issue_fire && remaining_q == LEN_WIDTH'(burst_c)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run bookkeeping: address/remaining, credit, delivered count, FIFO pointers, error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            total_q      <= '0;
            delivered_q  <= '0;
            pending_q    <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_lines;
                total_q     <= cmd_lines;
                delivered_q <= '0;
            end else begin
                if (issue_fire) begin
                    addr_q      <= addr_q + (ADDR_WIDTH'(burst_c) << 6);
                    remaining_q <= remaining_q - LEN_WIDTH'(burst_c);
                end
                if (out_hs) begin
                    delivered_q <= delivered_q + LEN_WIDTH'(1);
                end
            end
            pending_q    <= pending_q + (issue_fire ? CNT_W'(burst_c) : CNT_W'(0))
                                      - (out_hs ? CNT_W'(1) : CNT_W'(0));
            fifo_count_q <= fifo_count_q + (beat_ok ? CNT_W'(1) : CNT_W'(0))
                                         - (out_hs ? CNT_W'(1) : CNT_W'(0));
            if (beat_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (out_hs) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (stray) begin
                err_q <= 1'b1;
            end
        end
    end

    // Return buffer storage (contents are don't-care until written)
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            fifo_mem[wr_ptr_q] <= avm_readdata;
        end
    end

`ifdef HOST_RD_FETCH_STATS_EN
    // Saturating counters of delivered lines and stalled request cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lines <= '0;
            stat_stall <= '0;
        end else begin
            if (out_hs && stat_lines != 32'hFFFF_FFFF) begin
                stat_lines <= stat_lines + 32'd1;
            end
            if (avm_read && avm_waitrequest && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_host_rd_line_fetcher.sv
// Randomized bench for host_rd_line_fetcher with an Avalon read responder and
// a descriptor-level reference model of bursts and returned lines.
module tb_host_rd_line_fetcher;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 48;
    localparam int unsigned BW = 3;
    localparam int unsigned LW = 16;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_lines;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [BW-1:0] avm_burstcount;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          err;

    host_rd_line_fetcher dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_lines         (cmd_lines),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .done              (done),
        .err               (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected bursts, expected stream lines, and the responder's return queue
    logic [AW-1:0] q_req_addr[$];
    int            q_req_burst[$];
    logic [AW-1:0] q_line_addr[$];
    bit            q_line_last[$];
    logic [AW-1:0] q_ret_addr[$];
    int            q_ret_time[$];

    int            cyc = 0;
    int            p_wait = 0;
    int            p_ready = 100;
    int            force_stall = 0;
    int            ready_block = 0;
    int            pend_model = 0;
    bit            done_due = 0;
    bit            idle_due = 0;
    bit            err_exp = 0;
    bit            first_req_due = 0;
    bit            prev_stall = 0;
    bit            accepted = 0;
    bit            inject_stray = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [BW-1:0] prev_burst = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic [31:0]   seed;
        seed = a[37:6];
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = (seed * 32'h9E37_79B1) ^ (32'(i) << 24) ^ 32'h5A5A_0F0F;
        end
        return d;
    endfunction

    // Reference plan: stream lines in address order, bursts = largest aligned size fitting the remainder
    task automatic plan_run(input logic [AW-1:0] a0, input int n);
        logic [AW-1:0] a;
        int            r;
        int            b;
        for (int i = 0; i < n; i++) begin
            q_line_addr.push_back(a0 + AW'(i * 64));
            q_line_last.push_back(i == n - 1);
        end
        a = a0;
        r = n;
        while (r > 0) begin
            if (a % 256 == 0 && r >= 4)      b = 4;
            else if (a % 128 == 0 && r >= 2) b = 2;
            else                             b = 1;
            q_req_addr.push_back(a);
            q_req_burst.push_back(b);
            a = a + AW'(b * 64);
            r = r - b;
        end
    endtask

    // One cycle of checking and responder/consumer activity, called at the falling edge
    task automatic service();
        cyc++;
        accepted = 0;
        check("done", DW'(done), DW'(done_due));
        if (idle_due) check("cmd_ready_after_done", DW'(cmd_ready), DW'(1));
        idle_due = done_due;
        done_due = 0;
        check("err", DW'(err), DW'(err_exp));
        check("credit_bound", DW'(pend_model <= DEPTH), DW'(1));
        if (first_req_due) check("first_req", DW'(avm_read), DW'(1));
        first_req_due = 0;
        if (prev_stall) begin
            check("stall_read", DW'(avm_read), DW'(1));
            check("stall_addr", DW'(avm_address), DW'(prev_addr));
            check("stall_burst", DW'(avm_burstcount), DW'(prev_burst));
        end
        if (ready_block == 1) begin
            check("credit_full", DW'(pend_model), DW'(DEPTH));
            check("credit_hold", DW'(avm_read), DW'(0));
        end

        if (cmd_valid && cmd_ready) begin
            accepted = 1;
            plan_run(cmd_addr, int'(cmd_lines));
            if (cmd_lines == '0) done_due = 1;
            else                 first_req_due = 1;
        end

        if (force_stall > 0) begin
            avm_waitrequest = 1'b1;
            if (avm_read) force_stall--;
        end else begin
            avm_waitrequest = (int'($urandom_range(99)) < p_wait);
        end
        if (avm_read && !avm_waitrequest) begin
            if (q_req_addr.size() == 0) begin
                check("unexpected_req", DW'(avm_read), DW'(0));
            end else begin
                check("req_addr", DW'(avm_address), DW'(q_req_addr[0]));
                check("req_burst", DW'(avm_burstcount), DW'(q_req_burst[0]));
                void'(q_req_addr.pop_front());
                void'(q_req_burst.pop_front());
            end
            for (int k = 0; k < int'(avm_burstcount); k++) begin
                q_ret_addr.push_back(avm_address + AW'(k * 64));
                q_ret_time.push_back(cyc + 1 + int'($urandom_range(3)));
            end
            pend_model += int'(avm_burstcount);
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        prev_burst = avm_burstcount;

        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        if (inject_stray) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = '1;
            inject_stray      = 0;
            err_exp           = 1;
        end else if (q_ret_addr.size() > 0 && q_ret_time[0] <= cyc && $urandom_range(3) != 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = line_data(q_ret_addr[0]);
            void'(q_ret_addr.pop_front());
            void'(q_ret_time.pop_front());
        end

        if (ready_block > 0) begin
            out_ready = 1'b0;
            ready_block--;
        end else begin
            out_ready = (int'($urandom_range(99)) < p_ready);
        end
        if (out_valid && out_ready) begin
            if (q_line_addr.size() == 0) begin
                check("unexpected_out", DW'(out_valid), DW'(0));
            end else begin
                check("out_data", out_data, line_data(q_line_addr[0]));
                check("out_last", DW'(out_last), DW'(q_line_last[0]));
                if (q_line_last[0]) done_due = 1;
                void'(q_line_addr.pop_front());
                void'(q_line_last.pop_front());
            end
            pend_model--;
        end
    endtask

    task automatic start_cmd(input logic [AW-1:0] a, input int n);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_addr  = a;
        cmd_lines = LW'(n);
        cmd_valid = 1'b1;
        service();
        while (!accepted && guard < 100) begin
            @(negedge clk);
            service();
            guard++;
        end
        if (!accepted) check("cmd_accept_timeout", DW'(0), DW'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        service();
    endtask

    task automatic flush_model();
        q_req_addr.delete();
        q_req_burst.delete();
        q_line_addr.delete();
        q_line_last.delete();
        q_ret_addr.delete();
        q_ret_time.delete();
        pend_model    = 0;
        done_due      = 0;
        idle_due      = 0;
        first_req_due = 0;
        prev_stall    = 0;
        ready_block   = 0;
        force_stall   = 0;
    endtask

    task automatic finish_run();
        int guard;
        guard = 0;
        while ((q_line_addr.size() != 0 || done_due || idle_due) && guard < 20000) begin
            @(negedge clk);
            service();
            guard++;
        end
        if (guard >= 20000) begin
            check("run_timeout", DW'(0), DW'(1));
            flush_model();
        end
    endtask

    task automatic run(input logic [AW-1:0] a, input int n);
        start_cmd(a, n);
        finish_run();
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", DW'(cmd_ready), DW'(1));
        check("rst_avm_read", DW'(avm_read), DW'(0));
        check("rst_avm_address", DW'(avm_address), DW'(0));
        check("rst_avm_burst", DW'(avm_burstcount), DW'(1));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_last", DW'(out_last), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_err", DW'(err), DW'(0));
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            guard;
        reset_n           = 1'b0;
        cmd_valid         = 1'b0;
        cmd_addr          = '0;
        cmd_lines         = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        out_ready         = 1'b0;
        #1;
        check_reset_values();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Aligned run, misaligned start, address wrap
        run(48'h1000, 8);
        run(48'h1040, 7);
        run(48'hFFFF_FFFF_FF80, 6);

        // Consumer blocked: requests stop at FIFO_DEPTH pending lines
        ready_block = 80;
        run(48'h2000, 64);

        // Stalled first request
        force_stall = 5;
        run(48'h3000, 4);

        // Zero-length run
        run(48'h4000, 0);

        // Random runs with random stalls and backpressure
        p_wait  = 30;
        p_ready = 70;
        for (int i = 0; i < 10; i++) begin
            ra = {16'($urandom), 32'($urandom)};
            ra[5:0] = 6'd0;
            run(ra, int'($urandom_range(40)));
        end

        // Stray beat while idle sets sticky err
        @(negedge clk);
        inject_stray = 1;
        service();
        for (int i = 0; i < 4; i++) begin
            ra = {16'($urandom), 32'($urandom)};
            ra[5:0] = 6'd0;
            run(ra, int'($urandom_range(1, 20)));
        end

        // Reset asserted while draining
        p_wait      = 0;
        p_ready     = 100;
        ready_block = 300;
        start_cmd(48'h5000, 24);
        guard = 0;
        while (q_req_addr.size() != 0 && guard < 1000) begin
            @(negedge clk);
            service();
            guard++;
        end
        check("drain_reached", DW'(q_req_addr.size()), DW'(0));
        repeat (2) begin
            @(negedge clk);
            service();
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_values();
        flush_model();
        err_exp           = 0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run(48'h6040, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
